// File: rtl/msrv32_fetch_sequencer.sv
`default_nettype none
//==============================================================================
// Module : msrv32_fetch_sequencer
// Desc   : Program counter owner and single-outstanding instruction fetch
//          sequencer for msrv32 (boot / sequential / branch / trap / mret).
// Rev    : 1.0  initial release
//==============================================================================
module msrv32_fetch_sequencer #(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
    parameter int          WAIT_LIMIT   = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        stall_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_target_in,
    input  logic        trap_taken_in,
    input  logic [31:0] trap_vector_in,
    input  logic        mret_in,
    input  logic [31:0] epc_in,
    input  logic        imem_ready_in,
    input  logic [31:0] imem_rdata_in,
    output logic        imem_req_out,
    output logic [31:0] iaddr_out,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        instr_valid_out,
    output logic        flush_out,
    output logic        misaligned_out,
    output logic        fetch_timeout_out
);

    localparam int                 c_CNT_W    = $clog2(WAIT_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT    = c_CNT_W'(WAIT_LIMIT);
    localparam logic [c_CNT_W-1:0] c_LIMIT_M1 = c_CNT_W'(WAIT_LIMIT - 1);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [31:0]          r_fetch_pc;
    logic [31:0]          r_iaddr;
    logic [31:0]          r_pc;
    logic [31:0]          r_instr;
    logic                 r_valid;
    logic                 r_flush;
    logic                 r_misal;
    logic                 r_timeout;
    logic [c_CNT_W-1:0]   r_wait_cnt;

    logic                 w_redir;
    logic                 w_misal;
    logic [31:0]          w_target;
    logic                 w_req;
    logic [31:0]          w_iaddr;
    logic                 w_stuck;
    logic                 w_take;
    logic                 w_unused;

    assign w_unused = &{1'b0, trap_vector_in[1:0]};

    always_comb begin
        w_redir  = 1'b0;
        w_misal  = 1'b0;
        w_target = branch_target_in;
        if (trap_taken_in) begin
            w_redir  = 1'b1;
            w_target = {trap_vector_in[31:2], 2'b00};
        end else if (mret_in) begin
            w_target = epc_in;
            if (epc_in[1:0] == 2'b00) w_redir = 1'b1;
            else                      w_misal = 1'b1;
        end else if (branch_taken_in) begin
            if (branch_target_in[1:0] == 2'b00) w_redir = 1'b1;
            else                                w_misal = 1'b1;
        end

        // DRAIN must keep presenting the killed request's address until imem answers
        w_iaddr = (r_state == S_DRAIN) ? r_iaddr : r_fetch_pc;
        case (r_state)
            S_FETCH:         w_req = !r_valid || !stall_in;
            S_WAIT, S_DRAIN: w_req = 1'b1;
            default:         w_req = 1'b0;
        endcase
        w_stuck = w_req && !imem_ready_in;
        w_take  = w_req && imem_ready_in && !w_redir && (r_state != S_DRAIN);

        w_next = r_state;
        case (r_state)
            S_BOOT:          w_next = S_FETCH;
            S_FETCH, S_WAIT: w_next = w_stuck ? (w_redir ? S_DRAIN : S_WAIT) : S_FETCH;
            S_DRAIN:         w_next = imem_ready_in ? S_FETCH : S_DRAIN;
            default:         w_next = S_BOOT;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_state <= S_BOOT;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_fetch_pc <= BOOT_ADDRESS;
            r_iaddr    <= BOOT_ADDRESS;
            r_pc       <= BOOT_ADDRESS;
            r_instr    <= 32'h0;
            r_valid    <= 1'b0;
            r_flush    <= 1'b0;
            r_misal    <= 1'b0;
            r_timeout  <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            r_iaddr <= w_iaddr;
            r_flush <= w_redir && (r_state != S_DRAIN);
            r_misal <= w_misal;

            if (w_redir)     r_fetch_pc <= w_target;
            else if (w_take) r_fetch_pc <= r_fetch_pc + 32'd4;

            if (w_take) begin
                r_instr <= imem_rdata_in;
                r_pc    <= w_iaddr;
            end

            if (w_redir)                   r_valid <= 1'b0;
            else if (w_take)               r_valid <= 1'b1;
            else if (r_valid && !stall_in) r_valid <= 1'b0;

            if (w_next == S_WAIT) begin
                if (r_wait_cnt != c_LIMIT) r_wait_cnt <= r_wait_cnt + 1'b1;
                r_timeout <= (r_wait_cnt == c_LIMIT_M1);
            end else begin
                r_wait_cnt <= '0;
                r_timeout  <= 1'b0;
            end
        end
    end

    assign imem_req_out      = w_req;
    assign iaddr_out         = w_iaddr;
    assign pc_out            = r_pc;
    assign instr_out         = r_instr;
    assign instr_valid_out   = r_valid;
    assign flush_out         = r_flush;
    assign misaligned_out    = r_misal;
    assign fetch_timeout_out = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_msrv32_fetch_sequencer.sv
`default_nettype none
//==============================================================================
// Module : tb_msrv32_fetch_sequencer
// Desc   : Self-checking bench: vector table, directed corner sequences and
//          randomized traffic against a request-level reference model.
// Rev    : 1.0  initial release
//==============================================================================
module tb_msrv32_fetch_sequencer;

    localparam int          c_WL   = 6;
    localparam logic [31:0] c_BOOT = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, br = 1'b0, tr = 1'b0, mr = 1'b0, rdy = 1'b0;
    logic [31:0] bt = '0, tv = '0, ep = '0, rdata = '0;
    logic        req, valid, flush, mis, tmo;
    logic [31:0] iaddr, pc, instr;

    int total = 0;
    int bad   = 0;

    msrv32_fetch_sequencer #(.BOOT_ADDRESS(c_BOOT), .WAIT_LIMIT(c_WL)) dut (
        .clk_in(clk), .rst_in(rst), .stall_in(stall),
        .branch_taken_in(br), .branch_target_in(bt),
        .trap_taken_in(tr), .trap_vector_in(tv),
        .mret_in(mr), .epc_in(ep),
        .imem_ready_in(rdy), .imem_rdata_in(rdata),
        .imem_req_out(req), .iaddr_out(iaddr), .pc_out(pc), .instr_out(instr),
        .instr_valid_out(valid), .flush_out(flush), .misaligned_out(mis),
        .fetch_timeout_out(tmo)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks the outstanding request (if any) rather than FSM states
    bit          m_boot, m_pend, m_disc, m_valid, m_flush, m_mis, m_to;
    logic [31:0] m_paddr, m_fpc, m_pc, m_instr;
    int          m_run;

    task automatic model_reset();
        m_boot = 0; m_pend = 0; m_disc = 0; m_valid = 0;
        m_flush = 0; m_mis = 0; m_to = 0; m_run = 0;
        m_paddr = c_BOOT; m_fpc = c_BOOT; m_pc = c_BOOT; m_instr = '0;
    endtask

    task automatic model_step();
        bit          e_req, acc, mis_n;
        logic [31:0] e_addr, tgt;
        e_req  = !m_boot ? 1'b0 : (m_pend ? 1'b1 : (!m_valid || !stall));
        e_addr = m_pend ? m_paddr : m_fpc;
        chk("m_req", req, e_req);
        if (e_req) chk("m_iaddr", iaddr, e_addr);
        chk("m_valid", valid, m_valid);
        chk("m_pc", pc, m_pc);
        chk("m_instr", instr, m_instr);
        chk("m_flush", flush, m_flush);
        chk("m_misal", mis, m_mis);
        chk("m_tmo", tmo, m_to);

        acc = 0; mis_n = 0; tgt = '0;
        if (tr)      begin acc = 1; tgt = tv & ~32'd3; end
        else if (mr) begin if (ep % 4 == 0) begin acc = 1; tgt = ep; end else mis_n = 1; end
        else if (br) begin if (bt % 4 == 0) begin acc = 1; tgt = bt; end else mis_n = 1; end

        m_flush = 0; m_mis = mis_n; m_to = 0;
        if (!m_boot) begin
            m_boot = 1;
            if (acc) begin m_fpc = tgt; m_flush = 1; m_valid = 0; end
            m_run = 0;
        end else if (acc) begin
            m_flush = !(m_pend && m_disc);
            m_fpc = tgt; m_valid = 0;
            if (e_req && !rdy) begin m_pend = 1; m_paddr = e_addr; m_disc = 1; end
            else begin m_pend = 0; m_disc = 0; end
            m_run = 0;
        end else if (e_req && rdy) begin
            if (!m_disc) begin
                m_instr = rdata; m_pc = e_addr; m_valid = 1; m_fpc = e_addr + 32'd4;
            end
            m_pend = 0; m_disc = 0; m_run = 0;
        end else begin
            if (e_req) begin m_pend = 1; m_paddr = e_addr; end
            if (m_valid && !stall) m_valid = 0;
            if (e_req && !m_disc) begin m_run++; m_to = (m_run == c_WL); end
            else m_run = 0;
        end
    endtask

    task automatic cyc(input logic s, input logic r, input logic [31:0] d,
                       input logic b, input logic [31:0] bta, input logic t,
                       input logic [31:0] tva, input logic m, input logic [31:0] epa);
        @(negedge clk);
        stall = s; rdy = r; rdata = d; br = b; bt = bta; tr = t; tv = tva; mr = m; ep = epa;
        #1;
        model_step();
    endtask

    task automatic c(input logic r, input logic [31:0] d);
        cyc(1'b0, r, d, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; stall = 0; br = 0; tr = 0; mr = 0; rdy = 0;
        #1;
        chk("rst_req", req, 1'b0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_pc", pc, c_BOOT);
        chk("rst_instr", instr, 32'h0);
        chk("rst_flush", flush, 1'b0);
        chk("rst_misal", mis, 1'b0);
        chk("rst_tmo", tmo, 1'b0);
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    typedef struct {
        logic        st;
        logic        rdy;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_iaddr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int npulse;
        int lowrun;
        logic [31:0] r32;

        tbl[0] = '{1'b0, 1'b1, 32'hA0, 1'b0, 32'h00, 1'b0, 32'h0, 32'h0};
        tbl[1] = '{1'b0, 1'b1, 32'hA1, 1'b1, 32'h00, 1'b0, 32'h0, 32'h0};
        tbl[2] = '{1'b0, 1'b1, 32'hA2, 1'b1, 32'h04, 1'b1, 32'h0, 32'hA1};
        tbl[3] = '{1'b0, 1'b1, 32'hA3, 1'b1, 32'h08, 1'b1, 32'h4, 32'hA2};
        tbl[4] = '{1'b1, 1'b1, 32'hA4, 1'b0, 32'h00, 1'b1, 32'h8, 32'hA3};
        tbl[5] = '{1'b0, 1'b1, 32'hA5, 1'b1, 32'h0C, 1'b1, 32'h8, 32'hA3};
        tbl[6] = '{1'b0, 1'b1, 32'hA6, 1'b1, 32'h10, 1'b1, 32'hC, 32'hA5};
        tbl[7] = '{1'b0, 1'b0, 32'hA7, 1'b1, 32'h14, 1'b1, 32'h10, 32'hA6};
        tbl[8] = '{1'b0, 1'b1, 32'hA8, 1'b1, 32'h14, 1'b0, 32'h10, 32'hA6};
        tbl[9] = '{1'b0, 1'b1, 32'hA9, 1'b1, 32'h18, 1'b1, 32'h14, 32'hA8};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].st, tbl[i].rdy, tbl[i].rd, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
            chk("t_req", req, tbl[i].e_req);
            if (tbl[i].e_req) chk("t_iaddr", iaddr, tbl[i].e_iaddr);
            chk("t_valid", valid, tbl[i].e_valid);
            chk("t_pc", pc, tbl[i].e_pc);
            chk("t_instr", instr, tbl[i].e_instr);
        end

        // imem wait at 0x8 for three cycles, data on the fourth
        do_reset();
        c(1, 32'h1); c(1, 32'h2); c(1, 32'h3);
        c(0, 32'h0); chk("A_iaddr0", iaddr, 32'h8);
        c(0, 32'h0); chk("A_iaddr1", iaddr, 32'h8);
        c(0, 32'h0); chk("A_iaddr2", iaddr, 32'h8);
        c(1, 32'hCAFE_0008); chk("A_iaddr3", iaddr, 32'h8);
        c(1, 32'h5); chk("A_instr", instr, 32'hCAFE_0008);
        chk("A_pc", pc, 32'h8); chk("A_valid", valid, 1'b1);

        // branch during WAIT drains the old request
        do_reset();
        c(1, 32'h0); c(1, 32'h10); c(0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        c(1, 32'hDEAD_BEEF);
        chk("B_flush", flush, 1'b1); chk("B_drain_iaddr", iaddr, 32'h4); chk("B_valid0", valid, 1'b0);
        c(1, 32'h11);
        chk("B_iaddr", iaddr, 32'h100); chk("B_valid1", valid, 1'b0);
        c(1, 32'h12);
        chk("B_pc", pc, 32'h100); chk("B_instr", instr, 32'h11);

        // trap beats branch; vector low bits cleared
        do_reset();
        c(1, 32'h0); c(1, 32'h20);
        cyc(1'b0, 1'b1, 32'h21, 1'b1, 32'h300, 1'b1, 32'h203, 1'b0, 32'h0);
        c(1, 32'h22);
        chk("C_iaddr", iaddr, 32'h200); chk("C_flush", flush, 1'b1);
        c(1, 32'h23);
        chk("C_pc", pc, 32'h200); chk("C_instr", instr, 32'h22);

        // misaligned branch target is ignored apart from the pulse
        do_reset();
        c(1, 32'h0); c(1, 32'h30);
        cyc(1'b0, 1'b1, 32'h31, 1'b1, 32'h102, 1'b0, 32'h0, 1'b0, 32'h0);
        c(1, 32'h32);
        chk("D_misal", mis, 1'b1); chk("D_flush", flush, 1'b0);
        chk("D_iaddr", iaddr, 32'h8); chk("D_pc", pc, 32'h4);
        c(1, 32'h33);
        chk("D_misal_end", mis, 1'b0);

        // long wait: exactly one timeout pulse
        do_reset();
        c(1, 32'h0); c(1, 32'h40);
        npulse = 0;
        for (int i = 0; i < c_WL + 4; i++) begin c(0, 32'h0); npulse += int'(tmo); end
        c(1, 32'h41); npulse += int'(tmo);
        c(1, 32'h42); npulse += int'(tmo);
        chk("E_pulses", npulse, 1);

        // stall holds the slot for five cycles
        do_reset();
        c(1, 32'h0); c(1, 32'h55);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1, $urandom, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
            chk("F_instr", instr, 32'h55); chk("F_req", req, 1'b0);
        end
        c(1, 32'h56);
        chk("F_iaddr", iaddr, 32'h4);

        // asynchronous reset in the middle of WAIT
        do_reset();
        c(1, 32'h0); c(1, 32'h60); c(0, 32'h0); c(0, 32'h0);
        #3 rst = 1'b1;
        #1;
        chk("G_req", req, 1'b0); chk("G_valid", valid, 1'b0); chk("G_pc", pc, c_BOOT);
        rdy = 1'b1;
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        c(1, 32'h61); c(1, 32'h62); c(1, 32'h63);
        chk("G_pc_after", pc, c_BOOT); chk("G_instr_after", instr, 32'h62);

        // randomized traffic against the model
        do_reset();
        lowrun = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            if ($urandom_range(0, 39) == 0) lowrun = c_WL + $urandom_range(0, 3);
            r32 = $urandom;
            cyc(($urandom_range(0, 3) == 0),
                (lowrun > 0) ? 1'b0 : ($urandom_range(0, 2) != 0),
                $urandom,
                ($urandom_range(0, 9) == 0), (r32 & ~32'd3) | (($urandom_range(0, 4) == 0) ? ($urandom & 32'd3) : 32'd0),
                ($urandom_range(0, 29) == 0), $urandom,
                ($urandom_range(0, 19) == 0), ($urandom & ~32'd3) | (($urandom_range(0, 3) == 0) ? 32'd2 : 32'd0));
            if (lowrun > 0) lowrun--;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
